// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing the single FIFO write port among
//            NREQ producers in the write-clock domain. One requester holds
//            the grant for a burst of up to MAX_BURST beats. Every beat is
//            gated by wfull. wen doubles as the write-pointer increment.
//            Nothing is buffered: accepted data goes straight to memory.
// Ports    : wclk       - write-domain clock (rising edge)
//            wrst_n     - asynchronous active-low reset
//            req_valid  - per-requester data valid        [NREQ]
//            req_data   - requester i at [i*DSIZE +: DSIZE]
//            req_ready  - per-requester accept            [NREQ]
//            wfull      - FIFO full flag
//            wen        - memory write enable / wptr increment
//            wdata      - memory write data
//            grant_vld  - a requester holds the grant
//            grant_id   - index of the grant owner
//            burst_end  - pulse in the cycle the grant is released
// Options  : WARB_TAG_EN - when defined, wdata = {owner, data} and is
//            DSIZE+clog2(NREQ) bits wide.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DSIZE-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      wfull,
  output logic                      wen,
`ifdef WARB_TAG_EN
  output logic [DSIZE+$clog2(NREQ)-1:0] wdata,
`else
  output logic [DSIZE-1:0]          wdata,
`endif
  output logic                      grant_vld,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      burst_end
);

  localparam int c_IDW = $clog2(NREQ);
  localparam int c_CW  = $clog2(MAX_BURST + 1);
  localparam logic [c_CW-1:0]  c_LAST_BEAT = c_CW'(MAX_BURST - 1);
  localparam logic [c_IDW-1:0] c_LAST_ID   = c_IDW'(NREQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_IDW-1:0]   r_owner;
  logic [c_IDW-1:0]   r_rr_ptr;
  logic [c_CW-1:0]    r_beat_cnt;

  logic [DSIZE-1:0]   w_req_data [NREQ];
  logic               w_granted;
  logic               w_owner_valid;
  logic               w_beat;
  logic               w_release;
  logic [c_IDW-1:0]   w_owner_inc;
  logic [c_IDW-1:0]   w_scan_start;
  logic               w_hi_found;
  logic [c_IDW-1:0]   w_hi_id;
  logic               w_lo_found;
  logic [c_IDW-1:0]   w_lo_id;
  logic [c_IDW-1:0]   w_scan_id;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_req_data[gi] = req_data[gi*DSIZE +: DSIZE];
  end

  assign w_granted     = (r_state == ST_GRANT);
  assign w_owner_valid = req_valid[r_owner];
  assign w_beat        = w_granted && w_owner_valid && !wfull;
  // Full never causes release; only a finished burst or a dropped valid does.
  assign w_release     = w_granted &&
                         ((w_beat && (r_beat_cnt == c_LAST_BEAT)) || !w_owner_valid);
  assign w_owner_inc   = (r_owner == c_LAST_ID) ? '0 : r_owner + 1'b1;

  // On release the scan restarts just past the old owner, so the old owner
  // is reached last and only wins when nobody else is valid.
  assign w_scan_start  = w_granted ? w_owner_inc : r_rr_ptr;

  // Circular priority scan split in two halves: lowest valid index at or
  // above the start point, falling back to the lowest valid index overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_id    = '0;
    w_lo_found = 1'b0;
    w_lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_id    = c_IDW'(i);
        if (c_IDW'(i) >= w_scan_start) begin
          w_hi_found = 1'b1;
          w_hi_id    = c_IDW'(i);
        end
      end
    end
  end

  assign w_scan_id = w_hi_found ? w_hi_id : w_lo_id;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_lo_found) begin
            r_state <= ST_GRANT;
            r_owner <= w_scan_id;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_beat_cnt <= '0;
            r_rr_ptr   <= w_owner_inc;
            if (w_lo_found) begin
              r_owner <= w_scan_id;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (w_granted && !wfull) ? (NREQ'(1) << r_owner) : '0;
  assign wen       = w_beat;
  assign grant_vld = w_granted;
  assign grant_id  = w_granted ? r_owner : '0;
  assign burst_end = w_release;

`ifdef WARB_TAG_EN
  assign wdata = w_granted ? {r_owner, w_req_data[r_owner]} : '0;
`else
  assign wdata = w_granted ? w_req_data[r_owner] : '0;
`endif

endmodule
`default_nettype wire
